branch_pattern_table: RTL and testbench
=======================================

# branch_pattern_table

Parametrised branch pattern history table for the fetch stage. It holds 2^INDEX_BITS saturating counters of CTR_BITS each, indexed by PC bits XORed with an optional global history register (gshare). It supplies a registered taken/not-taken prediction one cycle after a lookup. Resolved branches from execute train it through a separate update port.

## Interface
- INDEX_BITS, 6: table index width; 2^INDEX_BITS entries.
- CTR_BITS, 2: counter width, ≥2.
- GHR_BITS, 4: global history length, 0..INDEX_BITS; 0 = pure PC-indexed (bimodal), no GHR.
- PC_LSB, 2: lowest PC bit used for indexing.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- pred_valid  input  1  lookup request this cycle.
- pred_pc  input  32  PC of the branch being looked up.
- pred_out_valid  output  1  registered; high the cycle after an accepted lookup.
- pred_taken  output  1  registered; MSB of the looked-up counter.
- pred_ctr  output  CTR_BITS  registered; counter value used.
- pred_index  output  INDEX_BITS  registered; index used (carried down the pipe to the update port).
- update_valid  input  1  resolved branch training request.
- update_index  input  INDEX_BITS  entry to train (the pred_index returned at lookup).
- update_taken  input  1  actual branch outcome.
- ghr  output  max(GHR_BITS,1)  current global history; reads 0 when GHR_BITS=0.

## Operation
- Lookup index = pred_pc[PC_LSB +: INDEX_BITS] XOR zero-extended ghr (GHR in low bits). When GHR_BITS=0, no XOR is applied.
- The lookup uses the ghr register value present in the lookup cycle. A same-cycle GHR update is not seen.
- Counter update:
  - update_taken=1: ctr+1, saturating at 2^CTR_BITS-1.
  - update_taken=0: ctr-1, saturating at 0.
  - No wrap in either direction.
  - For CTR_BITS=2 this gives 00→01→10→11→11 when taken and 11→10→01→00→00 when not taken.
- GHR, on update_valid: ghr <= {ghr[GHR_BITS-2:0], update_taken}, with the newest outcome in bit 0. Updates are non-speculative, in resolve order.
- Collision forwarding: if pred_valid and update_valid occur in the same cycle and the computed lookup index equals update_index, the prediction outputs show the post-update counter value.
- Only one update per cycle. Lookups and updates are independent and may occur every cycle.
- Reset:
  - Every counter is set to weakly-not-taken, 2^(CTR_BITS-1)-1 (01 for 2 bits).
  - ghr = 0, pred_out_valid = 0, pred_taken = 0, pred_ctr = 0, pred_index = 0.
  - rst has priority over update_valid and pred_valid in the same cycle; both are dropped.
- Table storage is flops with synchronous reset, so all entries are initialised in the single reset cycle. No init sequencer is needed.

## Timing
- Lookup latency is 1 cycle: inputs are sampled at edge N and outputs are valid after edge N.
- pred_out_valid is a registered copy of pred_valid (0 if rst). Prediction outputs hold their last value when pred_out_valid=0.
- The update write takes effect at the edge where update_valid is sampled. A lookup in the next cycle sees the new value.
- Reset takes effect at the first edge with rst=1. The first usable lookup is in the cycle after rst falls, and its result is valid one cycle later.
- Back-to-back updates to the same index accumulate: two taken updates move a counter up 2 steps.

## Test plan
- Reset (defaults): 2 cycles of rst, then lookup pred_pc=0x0000_0010 → pred_out_valid=1 next cycle, pred_index=4, pred_ctr=01, pred_taken=0, ghr=0.
- Saturation (GHR_BITS=0):
  - 3 taken updates to index 4, then lookup 0x10 → pred_ctr=11, pred_taken=1.
  - 1 more taken → still 11.
  - Then 4 not-taken → after each a lookup reads 10, 01, 00, 00.
- Forwarding (GHR_BITS=0, freshly reset): same cycle pred_pc=0x10 and update_index=4, update_taken=1 → next cycle pred_ctr=10, pred_taken=1. Index 5 stays at 01.
- GHR (defaults):
  - From reset, update index 0 with outcomes T,N,T,T → ghr=4'b1011.
  - Lookup pred_pc=0x10 → pred_index=4^11=15, pred_ctr=01.
- Reset mid-operation:
  - Train index 4 to 11 and ghr to nonzero (e.g. 4'b1011).
  - Assert rst for 1 cycle with update_valid=1 and pred_valid=1 also high in that cycle → update ignored, pred_out_valid=0 the next cycle.
  - Then lookup 0x10 → pred_index=4, pred_ctr=01, ghr=0.
- Throughput: lookup every cycle for 16 cycles with interleaved updates → pred_out_valid is continuously high, and each result matches a reference model with forwarding applied.

Source files
------------

// File: rtl/branch_pattern_table.sv
// branch_pattern_table
//   Fetch-stage branch pattern history table: 2^INDEX_BITS saturating
//   counters indexed by PC bits XORed with a global history register
//   (gshare). Registered prediction one cycle after a lookup; resolved
//   branches train the table and shift the history through the update port.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     pred_valid/pc   lookup request
//     pred_out_valid  registered copy of pred_valid
//     pred_taken      registered counter MSB
//     pred_ctr        registered counter value used
//     pred_index      registered index used (returned later as update_index)
//     update_valid    training request
//     update_index    entry to train
//     update_taken    resolved outcome
//     ghr             global history, newest outcome in bit 0 (0 if GHR_BITS=0)

// One table entry: a counter flop that resets to weakly-not-taken and loads
// the precomputed next value when selected for training.
module bpt_entry #(
   parameter int CTR_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [CTR_BITS-1:0] wr_ctr,
   output logic [CTR_BITS-1:0] ctr
);
   localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

   always_ff @(posedge clk) begin
      if (rst)        ctr <= CTR_WNT;
      else if (wr_en) ctr <= wr_ctr;
   end
endmodule

module branch_pattern_table #(
   parameter int INDEX_BITS = 6,
   parameter int CTR_BITS   = 2,
   parameter int GHR_BITS   = 4,
   parameter int PC_LSB     = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                pred_valid,
   input  logic [31:0]                         pred_pc,
   output logic                                pred_out_valid,
   output logic                                pred_taken,
   output logic [CTR_BITS-1:0]                 pred_ctr,
   output logic [INDEX_BITS-1:0]               pred_index,
   input  logic                                update_valid,
   input  logic [INDEX_BITS-1:0]               update_index,
   input  logic                                update_taken,
   output logic [((GHR_BITS>0)?GHR_BITS:1)-1:0] ghr
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

   logic [ENTRIES-1:0][CTR_BITS-1:0] ctr_tab;
   logic [GW-1:0]                    ghr_q;
   logic [INDEX_BITS-1:0]            ghr_ext;
   logic [INDEX_BITS-1:0]            lkp_idx;
   logic [CTR_BITS-1:0]              lkp_ctr;
   logic [CTR_BITS-1:0]              upd_cur;
   logic [CTR_BITS-1:0]              upd_nxt;

   // Single saturating incrementer/decrementer shared by every entry; only
   // one update per cycle so one copy suffices.
   assign upd_cur = ctr_tab[update_index];

   always_comb begin
      upd_nxt = upd_cur;
      if (update_taken) begin
         if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_ONE;
      end else begin
         if (upd_cur != '0)      upd_nxt = upd_cur - CTR_ONE;
      end
   end

   for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
      bpt_entry #(.CTR_BITS(CTR_BITS)) u_ent (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (update_valid && (update_index == INDEX_BITS'(g))),
         .wr_ctr (upd_nxt),
         .ctr    (ctr_tab[g])
      );
   end

   // Global history. Width 0 collapses to a constant zero bit.
   if (GHR_BITS == 0) begin : g_no_ghr
      assign ghr_q = '0;
   end else if (GHR_BITS == 1) begin : g_ghr1
      always_ff @(posedge clk) begin
         if (rst)               ghr_q <= '0;
         else if (update_valid) ghr_q <= update_taken;
      end
   end else begin : g_ghrn
      always_ff @(posedge clk) begin
         if (rst)               ghr_q <= '0;
         else if (update_valid) ghr_q <= {ghr_q[GW-2:0], update_taken};
      end
   end

   assign ghr = ghr_q;

   // History zero-extended into the low index bits.
   for (genvar b = 0; b < INDEX_BITS; b++) begin : g_gext
      if (b < GHR_BITS) begin : g_h
         assign ghr_ext[b] = ghr_q[b];
      end else begin : g_z
         assign ghr_ext[b] = 1'b0;
      end
   end

   assign lkp_idx = pred_pc[PC_LSB +: INDEX_BITS] ^ ghr_ext;

   // Same-cycle update to the looked-up entry is forwarded so the
   // prediction reflects the post-update counter.
   assign lkp_ctr = (update_valid && (update_index == lkp_idx)) ? upd_nxt
                                                               : ctr_tab[lkp_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_out_valid <= 1'b0;
         pred_taken     <= 1'b0;
         pred_ctr       <= '0;
         pred_index     <= '0;
      end else begin
         pred_out_valid <= pred_valid;
         if (pred_valid) begin
            pred_taken <= lkp_ctr[CTR_BITS-1];
            pred_ctr   <= lkp_ctr;
            pred_index <= lkp_idx;
         end
      end
   end
endmodule

// File: tb/tb_branch_pattern_table.sv
module tb_branch_pattern_table;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pred_valid = 1'b0;
   logic [31:0] pred_pc = '0;
   logic        pred_out_valid;
   logic        pred_taken;
   logic [1:0]  pred_ctr;
   logic [5:0]  pred_index;
   logic        update_valid = 1'b0;
   logic [5:0]  update_index = '0;
   logic        update_taken = 1'b0;
   logic [3:0]  ghr;

   branch_pattern_table #(
      .INDEX_BITS(6), .CTR_BITS(2), .GHR_BITS(4), .PC_LSB(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_out_valid (pred_out_valid),
      .pred_taken     (pred_taken),
      .pred_ctr       (pred_ctr),
      .pred_index     (pred_index),
      .update_valid   (update_valid),
      .update_index   (update_index),
      .update_taken   (update_taken),
      .ghr            (ghr)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; int ctr; } exp_t;
   exp_t sb[$];

   int         m_ctr[64];
   logic [3:0] m_ghr = '0;
   int         n_chk = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int c, input bit t);
      if (t) return (c >= 3) ? 3 : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   // One clock: drive, predict, advance the model at the edge, compare.
   task automatic step(input bit r, input bit pv, input logic [31:0] pc,
                       input bit uv, input int ui, input bit ut);
      exp_t e;
      bit   exp_v;
      int   idx;
      logic [31:0] uiv;
      uiv = ui;
      rst = r; pred_valid = pv; pred_pc = pc;
      update_valid = uv; update_index = uiv[5:0]; update_taken = ut;
      exp_v = pv && !r;
      if (exp_v) begin
         idx = int'(pc[7:2] ^ {2'b00, m_ghr});
         e.idx = idx;
         e.ctr = m_ctr[idx];
         if (uv && ui == idx) e.ctr = sat(e.ctr, ut);
         sb.push_back(e);
      end
      @(posedge clk);
      if (r) begin
         foreach (m_ctr[i]) m_ctr[i] = 1;
         m_ghr = '0;
      end else if (uv) begin
         m_ctr[ui] = sat(m_ctr[ui], ut);
         m_ghr = {m_ghr[2:0], ut};
      end
      #1;
      chk("out_valid", int'(pred_out_valid), int'(exp_v));
      if (exp_v) begin
         e = sb.pop_front();
         chk("sb_index", int'(pred_index), e.idx);
         chk("sb_ctr",   int'(pred_ctr),   e.ctr);
         chk("sb_taken", int'(pred_taken), e.ctr / 2);
      end
      chk("ghr", int'(ghr), int'(m_ghr));
      rst = 1'b0; pred_valid = 1'b0; update_valid = 1'b0;
   endtask

   task automatic lk(input int idx);
      logic [5:0] i6;
      i6 = 6'(idx) ^ {2'b00, m_ghr};
      step(0, 1, {24'h0, i6, 2'b00}, 0, 0, 0);
   endtask

   task automatic upd(input int idx, input bit t);
      step(0, 0, 32'h0, 1, idx, t);
   endtask

   task automatic do_rst();
      step(1, 0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      int ex[4];
      foreach (m_ctr[i]) m_ctr[i] = 1;

      // Reset defaults
      do_rst(); do_rst();
      chk("rst_ctr", int'(pred_ctr), 0);
      chk("rst_idx", int'(pred_index), 0);
      chk("rst_taken", int'(pred_taken), 0);
      step(0, 1, 32'h0000_0010, 0, 0, 0);
      chk("first_idx", int'(pred_index), 4);
      chk("first_ctr", int'(pred_ctr), 1);
      chk("first_ghr", int'(ghr), 0);

      // Saturation on entry 4 (pc chosen to cancel the history)
      upd(4, 1); upd(4, 1); upd(4, 1);
      lk(4);
      chk("sat_up_ctr", int'(pred_ctr), 3);
      chk("sat_up_taken", int'(pred_taken), 1);
      upd(4, 1); lk(4);
      chk("sat_hold", int'(pred_ctr), 3);
      ex = '{2, 1, 0, 0};
      for (int k = 0; k < 4; k++) begin
         upd(4, 0); lk(4);
         chk("sat_down", int'(pred_ctr), ex[k]);
      end

      // Forwarding
      do_rst();
      step(0, 1, 32'h0000_0010, 1, 4, 1);
      chk("fwd_ctr", int'(pred_ctr), 2);
      chk("fwd_taken", int'(pred_taken), 1);
      lk(5);
      chk("fwd_nb", int'(pred_ctr), 1);

      // History
      do_rst();
      upd(0, 1); upd(0, 0); upd(0, 1); upd(0, 1);
      chk("ghr_1011", int'(ghr), 11);
      step(0, 1, 32'h0000_0010, 0, 0, 0);
      chk("ghr_idx", int'(pred_index), 15);
      chk("ghr_ctr", int'(pred_ctr), 1);

      // Reset mid-operation drops same-cycle update and lookup
      do_rst();
      upd(4, 1); upd(4, 0); upd(4, 1); upd(4, 1);
      lk(4);
      chk("mid_ctr", int'(pred_ctr), 3);
      step(1, 1, 32'h0000_0010, 1, 4, 1);
      chk("mid_rst_valid", int'(pred_out_valid), 0);
      step(0, 1, 32'h0000_0010, 0, 0, 0);
      chk("mid_idx", int'(pred_index), 4);
      chk("mid_ctr_rst", int'(pred_ctr), 1);
      chk("mid_ghr", int'(ghr), 0);

      // Throughput: lookup every cycle, interleaved and colliding updates
      for (int k = 0; k < 16; k++) begin
         logic [31:0] pc;
         int          li, ui;
         bit          uv;
         pc = $urandom;
         li = int'(pc[7:2] ^ {2'b00, m_ghr});
         uv = (k % 3) != 2;
         ui = ($urandom_range(0, 1) == 1) ? li : int'($urandom_range(0, 63));
         step(0, 1, pc, uv, ui, 1'($urandom_range(0, 1)));
      end
      chk("sb_drain", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end
endmodule
